// File: rtl/alu_input_stage_fifo_if.sv
// Handshake bundle between the priority stage (master side) and the buffered
// ALU input stage (slave side). Bit 0 is the MSB on every bus.
interface alu_input_stage_fifo_if #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 64,
    parameter int CMD_W  = 4,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
);
    logic                      prio_valid;
    logic                      prio_ready;
    logic [0:CMD_W-1]          prio_cmd;
    logic [0:TAG_W-1]          prio_tag;
    logic                      prio_sext;
    logic [0:DIN_W-1]          prio_data1;
    logic [0:DIN_W-1]          prio_data2;
    logic                      alu_valid;
    logic                      alu_ready;
    logic [0:CMD_W-1]          alu_cmd;
    logic [0:TAG_W-1]          alu_tag;
    logic [0:DOUT_W-1]         alu_data1;
    logic [0:DOUT_W-1]         alu_data2;
    logic [0:$clog2(DEPTH)]    fifo_count;
    logic                      nop_drop;

    modport master (
        output prio_valid, prio_cmd, prio_tag, prio_sext, prio_data1, prio_data2, alu_ready,
        input  prio_ready, alu_valid, alu_cmd, alu_tag, alu_data1, alu_data2, fifo_count, nop_drop
    );

    modport slave (
        input  prio_valid, prio_cmd, prio_tag, prio_sext, prio_data1, prio_data2, alu_ready,
        output prio_ready, alu_valid, alu_cmd, alu_tag, alu_data1, alu_data2, fifo_count, nop_drop
    );
endinterface

// File: rtl/alu_input_stage_fifo.sv
// Buffered ALU input stage: extends operands at push time and queues them in a
// DEPTH-entry FIFO; the head entry is registered, so there is no fall-through.
module alu_input_stage_fifo #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 64,
    parameter int CMD_W  = 4,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                 c_clk,
    input  logic                 reset_n,
    alu_input_stage_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [0:CMD_W-1]  fifo_cmd_p1   [DEPTH];
    logic [0:TAG_W-1]  fifo_tag_p1   [DEPTH];
    logic [0:DOUT_W-1] fifo_data1_p1 [DEPTH];
    logic [0:DOUT_W-1] fifo_data2_p1 [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             nop_drop_p1;

    logic push;
    logic store;
    logic pop;

    function automatic logic [0:DOUT_W-1] extend(input logic [0:DIN_W-1] d, input logic sext);
        logic signed [DIN_W-1:0] sd;
        sd = d;
        if (sext)
            extend = DOUT_W'(sd);
        else
            extend = DOUT_W'(d);
    endfunction

    // ready depends only on occupancy, never on alu_ready
    assign bus.prio_ready = (count != FULL_CNT) & reset_n;
    assign bus.alu_valid  = (count != '0);

    assign push  = bus.prio_valid & bus.prio_ready;
    assign store = push & (bus.prio_cmd != '0);
    assign pop   = bus.alu_valid & bus.alu_ready;

    // stage p0 -> p1: control state (pointers, occupancy, no-op pulse)
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            nop_drop_p1 <= 1'b0;
        end else begin
            nop_drop_p1 <= push & (bus.prio_cmd == '0);
            if (store)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // stage p0 -> p1: entry storage, extension applied before the write
    always_ff @(posedge c_clk) begin
        if (store) begin
            fifo_cmd_p1[wr_ptr]   <= bus.prio_cmd;
            fifo_tag_p1[wr_ptr]   <= bus.prio_tag;
            fifo_data1_p1[wr_ptr] <= extend(bus.prio_data1, bus.prio_sext);
            fifo_data2_p1[wr_ptr] <= extend(bus.prio_data2, bus.prio_sext);
        end
    end

    // stage p1 -> ALU: head entry, zero whenever the FIFO is empty
    always_comb begin
        bus.alu_cmd   = '0;
        bus.alu_tag   = '0;
        bus.alu_data1 = '0;
        bus.alu_data2 = '0;
        if (bus.alu_valid) begin
            bus.alu_cmd   = fifo_cmd_p1[rd_ptr];
            bus.alu_tag   = fifo_tag_p1[rd_ptr];
            bus.alu_data1 = fifo_data1_p1[rd_ptr];
            bus.alu_data2 = fifo_data2_p1[rd_ptr];
        end
    end

    assign bus.fifo_count = count;
    assign bus.nop_drop   = nop_drop_p1;
endmodule

// File: tb/tb_alu_input_stage_fifo.sv
// Bench for alu_input_stage_fifo: a negedge scoreboard tracks every push/pop,
// plus directed sequences for extension, back-pressure, wrap, no-op and reset.
module tb_alu_input_stage_fifo;
    logic c_clk = 1'b0;
    logic reset_n = 1'b0;

    alu_input_stage_fifo_if #(.DIN_W(32), .DOUT_W(64), .CMD_W(4), .TAG_W(2), .DEPTH(4)) bus();

    alu_input_stage_fifo #(.DIN_W(32), .DOUT_W(64), .CMD_W(4), .TAG_W(2), .DEPTH(4)) dut (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    typedef struct {
        logic        sext;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [63:0] e1;
        logic [63:0] e2;
    } ext_vec_t;

    exp_t       sb[$];
    logic [3:0] pop_cmd[$];
    logic [1:0] pop_tag[$];
    int         total = 0;
    int         bad = 0;
    int         nop_cnt = 0;
    logic       nop_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ext_m(input logic [31:0] d, input logic s);
        if (s && d[31])
            return {32'hFFFF_FFFF, d};
        return {32'h0000_0000, d};
    endfunction

    // Scoreboard: checks state, then applies the transfers the coming edge will make
    initial begin : monitor
        exp_t e;
        logic rdy_m;
        forever begin
            @(negedge c_clk);
            if (!reset_n) begin
                chk("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
                chk("rst_prio_ready", 64'(bus.prio_ready), 64'd0);
                chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
                chk("rst_nop_drop", 64'(bus.nop_drop), 64'd0);
                chk("rst_alu_cmd", 64'(bus.alu_cmd), 64'd0);
                chk("rst_alu_data1", bus.alu_data1, 64'd0);
                sb.delete();
                nop_exp = 1'b0;
            end else begin
                chk("nop_drop", 64'(bus.nop_drop), 64'(nop_exp));
                if (bus.nop_drop) nop_cnt++;
                chk("fifo_count", 64'(bus.fifo_count), 64'(sb.size()));
                chk("alu_valid", 64'(bus.alu_valid), 64'(sb.size() != 0));
                rdy_m = (sb.size() != 4);
                chk("prio_ready", 64'(bus.prio_ready), 64'(rdy_m));
                if (sb.size() != 0) begin
                    chk("head_cmd", 64'(bus.alu_cmd), 64'(sb[0].cmd));
                    chk("head_tag", 64'(bus.alu_tag), 64'(sb[0].tag));
                    chk("head_data1", bus.alu_data1, sb[0].d1);
                    chk("head_data2", bus.alu_data2, sb[0].d2);
                    if (bus.alu_ready) begin
                        pop_cmd.push_back(bus.alu_cmd);
                        pop_tag.push_back(bus.alu_tag);
                        void'(sb.pop_front());
                    end
                end else begin
                    chk("empty_cmd", 64'(bus.alu_cmd), 64'd0);
                    chk("empty_data1", bus.alu_data1, 64'd0);
                end
                nop_exp = 1'b0;
                if (bus.prio_valid && rdy_m) begin
                    if (bus.prio_cmd == 4'h0) begin
                        nop_exp = 1'b1;
                    end else begin
                        e.cmd = bus.prio_cmd;
                        e.tag = bus.prio_tag;
                        e.d1  = ext_m(bus.prio_data1, bus.prio_sext);
                        e.d2  = ext_m(bus.prio_data2, bus.prio_sext);
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic set_req(input logic v, input logic [3:0] cmd, input logic [1:0] tag,
                           input logic sext, input logic [31:0] d1, input logic [31:0] d2);
        bus.prio_valid = v;
        bus.prio_cmd   = cmd;
        bus.prio_tag   = tag;
        bus.prio_sext  = sext;
        bus.prio_data1 = d1;
        bus.prio_data2 = d2;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic sext,
                        input logic [31:0] d1, input logic [31:0] d2);
        bit ok;
        ok = 1'b0;
        set_req(1'b1, cmd, tag, sext, d1, d2);
        for (int i = 0; i < 200; i++) begin
            @(negedge c_clk);
            if (bus.prio_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: cmd %h never accepted", cmd);
        end
        @(posedge c_clk); #1;
        bus.prio_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        bus.alu_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge c_clk);
            if (bus.fifo_count == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: fifo_count stuck at %0d", bus.fifo_count);
        end
        @(posedge c_clk); #1;
        bus.alu_ready = 1'b0;
    endtask

    initial begin : stim
        ext_vec_t   ev[4];
        logic [3:0] fill_cmd[5];
        logic [1:0] fill_tag[5];
        int         n0;

        ev[0] = '{1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 64'h0000_0000_7FFF_FFFF};
        ev[1] = '{1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 64'h0000_0000_8000_0001, 64'h0000_0000_FFFF_FFFF};
        ev[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
        ev[3] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 64'h0000_0000_1234_5678, 64'h0000_0000_8765_4321};
        fill_cmd = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
        fill_tag = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        set_req(1'b0, 4'h0, 2'd0, 1'b0, 32'h0, 32'h0);
        bus.alu_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge c_clk);
        #1 reset_n = 1'b1;
        @(negedge c_clk);
        chk("ready_after_reset", 64'(bus.prio_ready), 64'd1);
        @(posedge c_clk); #1;

        // Extension vectors, one entry at a time
        for (int i = 0; i < 4; i++) begin
            send(4'h3, 2'(i), ev[i].sext, ev[i].d1, ev[i].d2);
            @(negedge c_clk);
            chk("ext_data1", bus.alu_data1, ev[i].e1);
            chk("ext_data2", bus.alu_data2, ev[i].e2);
            @(posedge c_clk); #1 bus.alu_ready = 1'b1;
            @(posedge c_clk); #1 bus.alu_ready = 1'b0;
        end

        // Push into an empty FIFO: not visible until the following cycle
        set_req(1'b1, 4'h5, 2'd1, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A);
        @(negedge c_clk);
        chk("empty_push_valid_N", 64'(bus.alu_valid), 64'd0);
        @(posedge c_clk); #1 bus.prio_valid = 1'b0;
        @(negedge c_clk);
        chk("empty_push_valid_N1", 64'(bus.alu_valid), 64'd1);
        chk("empty_push_cmd_N1", 64'(bus.alu_cmd), 64'h5);
        @(posedge c_clk); #1;
        drain();

        // Fill with back-pressure, fifth request stalls
        pop_cmd.delete();
        pop_tag.delete();
        for (int i = 0; i < 4; i++)
            send(fill_cmd[i], fill_tag[i], 1'b0, 32'(i), ~32'(i));
        set_req(1'b1, fill_cmd[4], fill_tag[4], 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (3) begin
            @(negedge c_clk);
            chk("full_count", 64'(bus.fifo_count), 64'd4);
            chk("full_ready", 64'(bus.prio_ready), 64'd0);
        end
        @(posedge c_clk); #1 bus.alu_ready = 1'b1;
        send(fill_cmd[4], fill_tag[4], 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        drain();
        chk("fill_pops", 64'(pop_cmd.size()), 64'd5);
        for (int i = 0; i < 5 && i < pop_cmd.size(); i++) begin
            chk("fill_order_cmd", 64'(pop_cmd[i]), 64'(fill_cmd[i]));
            chk("fill_order_tag", 64'(pop_tag[i]), 64'(fill_tag[i]));
        end

        // Simultaneous push and pop at count 2 across pointer wrap
        pop_cmd.delete();
        pop_tag.delete();
        send(4'h1, 2'd0, 1'b0, 32'h11, 32'h22);
        send(4'h2, 2'd1, 1'b0, 32'h33, 32'h44);
        bus.alu_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(1'b1, 4'(i + 3), 2'(i), i[0], 32'h8000_0000 | 32'(i), 32'(i * 7));
            @(negedge c_clk);
            chk("pp_count", 64'(bus.fifo_count), 64'd2);
            @(posedge c_clk); #1;
        end
        bus.prio_valid = 1'b0;
        drain();
        chk("pp_pops", 64'(pop_cmd.size()), 64'd12);
        for (int i = 0; i < 12 && i < pop_cmd.size(); i++)
            chk("pp_order", 64'(pop_cmd[i]), 64'(i + 1));

        // No-op between two real commands
        pop_cmd.delete();
        pop_tag.delete();
        n0 = nop_cnt;
        send(4'h1, 2'd0, 1'b0, 32'h1, 32'h1);
        send(4'h0, 2'd1, 1'b0, 32'h2, 32'h2);
        send(4'h2, 2'd2, 1'b0, 32'h3, 32'h3);
        repeat (2) @(negedge c_clk);
        chk("nop_pulses", 64'(nop_cnt - n0), 64'd1);
        @(posedge c_clk); #1;
        drain();
        chk("nop_pops", 64'(pop_cmd.size()), 64'd2);
        if (pop_cmd.size() == 2) begin
            chk("nop_first_cmd", 64'(pop_cmd[0]), 64'h1);
            chk("nop_second_cmd", 64'(pop_cmd[1]), 64'h2);
        end

        // Reset with three entries queued and a push in flight
        send(4'h7, 2'd0, 1'b0, 32'h7, 32'h7);
        send(4'h8, 2'd1, 1'b0, 32'h8, 32'h8);
        send(4'h9, 2'd2, 1'b0, 32'h9, 32'h9);
        set_req(1'b1, 4'hA, 2'd3, 1'b0, 32'hA, 32'hA);
        @(negedge c_clk);
        chk("pre_reset_count", 64'(bus.fifo_count), 64'd3);
        @(posedge c_clk); #1;
        reset_n = 1'b0;
        bus.prio_valid = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(bus.alu_valid), 64'd0);
        chk("mid_reset_count", 64'(bus.fifo_count), 64'd0);
        chk("mid_reset_ready", 64'(bus.prio_ready), 64'd0);
        @(posedge c_clk); #1;
        @(posedge c_clk); #1 reset_n = 1'b1;
        @(negedge c_clk);
        chk("post_reset_ready", 64'(bus.prio_ready), 64'd1);
        chk("post_reset_count", 64'(bus.fifo_count), 64'd0);
        chk("post_reset_valid", 64'(bus.alu_valid), 64'd0);
        @(posedge c_clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
